// File: rtl/uart_stream_master_pkg.sv
// Shared constants for the UART stream master: register map, status bit
// positions and FSM state encoding.
package uart_stream_master_pkg;

  localparam logic [1:0] A_CLOCK  = 2'd0;
  localparam logic [1:0] A_CONFIG = 2'd1;
  localparam logic [1:0] A_STATUS = 2'd2;
  localparam logic [1:0] A_DATA   = 2'd3;

  localparam int ST_PAR     = 0;
  localparam int ST_OVR     = 1;
  localparam int ST_TXEMPTY = 2;
  localparam int ST_TXHALF  = 3;
  localparam int ST_TXFULL  = 4;
  localparam int ST_RXEMPTY = 5;
  localparam int ST_RXHALF  = 6;
  localparam int ST_RXFULL  = 7;

  localparam logic [2:0] S_INIT_CLK = 3'd0;
  localparam logic [2:0] S_INIT_CFG = 3'd1;
  localparam logic [2:0] S_STATUS   = 3'd2;
  localparam logic [2:0] S_TX_WR    = 3'd3;
  localparam logic [2:0] S_RX_RD    = 3'd4;

endpackage

// File: rtl/uart_stream_master_if.sv
// Register bus between the stream master and the UART register block;
// read data is combinational on addr within the same cycle.
interface uart_stream_master_if;
  import uart_stream_master_pkg::*;

  logic        cs;
  logic        wr;
  logic        rd;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output cs, output wr, output rd, output addr, output wdata, input rdata);
  modport slave  (input cs, input wr, input rd, input addr, input wdata, output rdata);

endinterface

// File: rtl/uart_stream_master.sv
// Drives a UART register block: programs divider/config, then polls status
// and moves bytes between the TX/RX streams and the data register.
module uart_stream_master
  import uart_stream_master_pkg::*;
#(
  parameter logic [15:0] P_CLK_DIV = 16'd434,
  parameter logic [6:0]  P_CONFIG  = 7'h63
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_tx_valid,
  input  logic [8:0]  i_tx_data,
  output logic        o_tx_ready,
  output logic        o_rx_valid,
  output logic [8:0]  o_rx_data,
  input  logic        i_rx_ready,
  input  logic        i_cfg_load,
  input  logic [15:0] i_clk_div,
  input  logic [6:0]  i_config,
  input  logic        i_err_clr,
  output logic        o_overrun,
  output logic        o_parity,
  output logic        o_init_done,
  output logic        o_cs,
  output logic        o_wr,
  output logic        o_rd,
  output logic [1:0]  o_addr,
  output logic [31:0] o_wdata,
  input  logic [31:0] i_rdata
);

  logic [2:0]  state_q, state_d;
  logic [15:0] div_q, div_d;
  logic [6:0]  cfg_q, cfg_d;
  logic        init_done_q, init_done_d;
  logic        prio_rx_q, prio_rx_d;
  logic        rx_valid_q, rx_valid_d;
  logic [8:0]  rx_data_q, rx_data_d;
  logic        overrun_q, overrun_d;
  logic        parity_q, parity_d;

  logic        tx_elig, rx_elig;
  logic        cs, wr, rd, tx_ready;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic        unused_rdata;

  assign unused_rdata = &{1'b0, i_rdata[31:9]};

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    cfg_d       = cfg_q;
    init_done_d = init_done_q;
    prio_rx_d   = prio_rx_q;
    rx_valid_d  = rx_valid_q;
    rx_data_d   = rx_data_q;
    overrun_d   = overrun_q;
    parity_d    = parity_q;
    cs          = 1'b0;
    wr          = 1'b0;
    rd          = 1'b0;
    addr        = A_CLOCK;
    wdata       = '0;
    tx_ready    = 1'b0;

    tx_elig = init_done_q && i_tx_valid && !i_rdata[ST_TXFULL];
    rx_elig = init_done_q && !i_rdata[ST_RXEMPTY] && (!rx_valid_q || i_rx_ready);

    if (i_rx_ready) rx_valid_d = 1'b0;
    // Clear first so an error sampled in this same cycle re-sets the flag.
    if (i_err_clr) begin
      overrun_d = 1'b0;
      parity_d  = 1'b0;
    end

    case (state_q)
      S_INIT_CLK: begin
        cs      = 1'b1;
        wr      = 1'b1;
        addr    = A_CLOCK;
        wdata   = {16'd0, div_q};
        state_d = S_INIT_CFG;
      end
      S_INIT_CFG: begin
        cs          = 1'b1;
        wr          = 1'b1;
        addr        = A_CONFIG;
        wdata       = {23'd0, 2'b11, cfg_q};
        init_done_d = 1'b1;
        state_d     = S_STATUS;
      end
      S_STATUS: begin
        cs   = 1'b1;
        rd   = 1'b1;
        addr = A_STATUS;
        if (i_rdata[ST_OVR]) overrun_d = 1'b1;
        if (i_rdata[ST_PAR]) parity_d  = 1'b1;
        if (rx_elig && (prio_rx_q || !tx_elig)) begin
          state_d   = S_RX_RD;
          prio_rx_d = 1'b0;
        end else if (tx_elig) begin
          state_d   = S_TX_WR;
          prio_rx_d = 1'b1;
        end
      end
      S_TX_WR: begin
        tx_ready = 1'b1;
        cs       = i_tx_valid;
        wr       = i_tx_valid;
        addr     = A_DATA;
        wdata    = {23'd0, i_tx_data};
        state_d  = S_STATUS;
      end
      S_RX_RD: begin
        cs         = 1'b1;
        rd         = 1'b1;
        addr       = A_DATA;
        rx_data_d  = i_rdata[8:0];
        rx_valid_d = 1'b1;
        state_d    = S_STATUS;
      end
      default: state_d = S_INIT_CLK;
    endcase

    // A reload lets the current access finish but never starts a stream access.
    if (i_cfg_load) begin
      div_d       = i_clk_div;
      cfg_d       = i_config;
      init_done_d = 1'b0;
      prio_rx_d   = prio_rx_q;
      state_d     = S_INIT_CLK;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_INIT_CLK;
      div_q       <= P_CLK_DIV;
      cfg_q       <= P_CONFIG;
      init_done_q <= 1'b0;
      prio_rx_q   <= 1'b1;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= '0;
      overrun_q   <= 1'b0;
      parity_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      cfg_q       <= cfg_d;
      init_done_q <= init_done_d;
      prio_rx_q   <= prio_rx_d;
      rx_valid_q  <= rx_valid_d;
      rx_data_q   <= rx_data_d;
      overrun_q   <= overrun_d;
      parity_q    <= parity_d;
    end
  end

  // Bus strobes are decoded from the current state; reset masks them so no
  // access is issued while the block is held in reset.
  assign o_cs        = cs & ~i_rst;
  assign o_wr        = wr & ~i_rst;
  assign o_rd        = rd & ~i_rst;
  assign o_addr      = i_rst ? A_CLOCK : addr;
  assign o_wdata     = i_rst ? 32'd0 : wdata;
  assign o_tx_ready  = tx_ready & ~i_rst;
  assign o_rx_valid  = rx_valid_q;
  assign o_rx_data   = rx_data_q;
  assign o_overrun   = overrun_q;
  assign o_parity    = parity_q;
  assign o_init_done = init_done_q;

endmodule

// File: doc/uart_stream_master.md
UART_STREAM_MASTER -- requirements
Module: uart_stream_master

Interface
REQ-001 Parameter P_CLK_DIV, default 16'd434, divider written at init (50 MHz / 115200).
REQ-002 Parameter P_CONFIG, default 7'h63, config written at init: 8-bit length code 3, no parity, 1 stop, rx/tx enabled.
REQ-003 Clock i_clk and reset i_rst SHALL be the first ports; i_rst is synchronous, active-high, clocked by i_clk.
REQ-004 Ports (name, direction, width, meaning):
- i_clk  in  1  clock.
- i_rst  in  1  sync reset.
- i_tx_valid  in  1  tx byte offered.
- i_tx_data  in  9  tx data.
- o_tx_ready  out  1  tx byte accepted this cycle.
- o_rx_valid  out  1  rx byte held.
- o_rx_data  out  9  rx data.
- i_rx_ready  in  1  consumer takes rx byte.
- i_cfg_load  in  1  pulse; reload divider/config.
- i_clk_div  in  16  divider for reload.
- i_config  in  7  config for reload.
- i_err_clr  in  1  clears sticky errors.
- o_overrun  out  1  sticky overrun.
- o_parity  out  1  sticky parity error.
- o_init_done  out  1  init sequence complete.
- o_cs  out  1  register chip select.
- o_wr  out  1  register write.
- o_rd  out  1  register read.
- o_addr  out  2  0 clock, 1 config, 2 status, 3 data.
- o_wdata  out  32  register write data.
- i_rdata  in  32  register read data, combinational on o_addr, same cycle.

Function
REQ-005 Every register transaction SHALL occupy exactly one cycle with o_cs=1; o_wr and o_rd are never both 1.
REQ-006 FSM states SHALL be INIT_CLK, INIT_CFG, STATUS, TX_WR, RX_RD.
REQ-007 INIT_CLK SHALL write {16'd0, div} to addr 0, then go to INIT_CFG.
REQ-008 INIT_CFG SHALL write {23'd0, 2'b11, cfg} to addr 1, clearing both buffers, then go to STATUS; o_init_done is set at the end of that cycle.
REQ-009 STATUS SHALL read addr 2 and sample i_rdata[7:0] as {rxfull, rxhalf, rxempty, txfull, txhalf, txempty, ovr, par}.
REQ-010 In STATUS, bits ovr and par SHALL OR into o_overrun and o_parity; this read also clears the hardware error flags.
REQ-011 TX is eligible when i_tx_valid=1 and txfull=0.
REQ-012 RX is eligible when rxempty=0 and o_rx_valid=0, or when o_rx_valid=1 and i_rx_ready=1 in the same cycle.
REQ-013 When both TX and RX are eligible, the FSM SHALL alternate between them, with priority going to the one not served last; after reset, RX has priority.
REQ-014 When neither is eligible, the FSM SHALL stay in STATUS and re-read status every cycle.
REQ-015 TX_WR: o_tx_ready=1; o_wr=i_tx_valid at addr 3 with o_wdata={23'd0, i_tx_data}; if i_tx_valid has dropped, no transaction occurs; next state is STATUS.
REQ-016 RX_RD: read addr 3 and load i_rdata[8:0] into o_rx_data; o_rx_valid=1 from the next cycle; next state is STATUS.
REQ-017 o_rx_valid SHALL clear on the cycle i_rx_ready=1, unless RX_RD reloads it in that same cycle.
REQ-018 o_tx_ready SHALL be 0 in all states other than TX_WR.
REQ-019 i_cfg_load in any state SHALL latch i_clk_div and i_config, clear o_init_done, and go to INIT_CLK next cycle; any in-flight TX_WR/RX_RD cycle completes normally.
REQ-020 i_err_clr SHALL clear the sticky flags; an error sampled in the same cycle wins (flag stays set).
REQ-021 The TX and RX streams SHALL be stalled (ready=0, no RX reads) until o_init_done=1.

Reset
REQ-022 On reset, state SHALL be INIT_CLK, and divider/config registers SHALL load from P_CLK_DIV/P_CONFIG.
REQ-023 On reset, o_rx_valid, o_rx_data, o_overrun, o_parity, o_init_done, o_tx_ready, o_cs, o_wr, and o_rd SHALL be 0; o_addr=0; o_wdata=0.
REQ-024 Reset mid-transaction SHALL abort it and restart the init sequence.

Structure
REQ-025 The shared package SHALL hold register address constants (A_CLOCK..A_DATA), status bit indices, and FSM state encoding.
REQ-026 The block SHALL be a single module with no sub-modules; it connects port-for-port to the UART register block.

Verification
REQ-027 Reset release: cycle 1 writes 0x1B2 to addr 0; cycle 2 writes 0x1E3 to addr 1; cycle 3 reads addr 2; o_init_done=1.
REQ-028 TX byte 0x41 with txfull=0: STATUS, then TX_WR writes 0x041 to addr 3 with o_tx_ready=1 for exactly one cycle.
REQ-029 Status rxempty=0 with data 0x155: RX_RD occurs, then o_rx_valid=1 and o_rx_data=0x155, held while i_rx_ready=0 and no further addr-3 read is issued.
REQ-030 TX and RX both eligible continuously: addr-3 accesses alternate read, write, read, write, each separated by one status read.
REQ-031 Status returns ovr=1 once: o_overrun=1 and stays set until i_err_clr; with an ovr=1 sample in the same cycle as i_err_clr, the flag stays 1.
REQ-032 i_cfg_load with div 0x0010 during traffic: the next two transactions are writes of 0x10 and {2'b11, cfg}, and o_tx_ready=0 throughout.
